// File: rtl/stream_pkt_pkg.sv
// stream_pkt_pkg: shared FSM encoding and round-robin helper for the packet arbiter
package stream_pkt_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/stream_pkt_arbiter_rr_pick.sv
// rr_pick: rotate-and-priority-encode, first requester at or after ptr wins
module rr_pick
#(
    parameter int N_INPUTS = 4,
    parameter int SRC_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic [N_INPUTS-1:0] req,
    input  logic [SRC_W-1:0]    ptr,
    output logic                found,
    output logic [SRC_W-1:0]    idx
);
    // scan from the farthest offset back to ptr so the nearest requester overwrites
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_INPUTS]) begin
                found = 1'b1;
                idx   = SRC_W'((int'(ptr) + k) % N_INPUTS);
            end
        end
    end
endmodule

// File: rtl/stream_pkt_arbiter.sv
// stream_pkt_arbiter: packet-atomic round-robin mux of N streams into a 2-entry skid output
module stream_pkt_arbiter
    import stream_pkt_pkg::*;
#(
    parameter int N_INPUTS      = 4,
    parameter int DIN_WIDTH     = 64,
    parameter int MAX_PKT_WORDS = 1024,
    parameter int SRC_W         = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_INPUTS*DIN_WIDTH-1:0] din,
    input  logic [N_INPUTS-1:0]           din_valid,
    input  logic [N_INPUTS-1:0]           din_last,
    output logic [N_INPUTS-1:0]           din_ready,
    output logic [DIN_WIDTH-1:0]          dout,
    output logic                          dout_valid,
    output logic                          dout_last,
    output logic [SRC_W-1:0]              dout_src,
    input  logic                          dout_ready,
    output logic                          pkt_err,
    output logic                          busy
);
    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
    state_t                r_state, w_state_nxt;
    logic [SRC_W-1:0]      r_grant, r_rr_ptr, w_pick_idx;
    logic [SRC_W-1:0]      r_dout_src, r_skid_src;
    logic [CNT_W-1:0]      r_word_cnt;
    logic [DIN_WIDTH-1:0]  r_dout, r_skid_data, w_din;
    logic                  r_dout_valid, r_dout_last, r_skid_valid, r_skid_last, r_pkt_err;
    logic                  w_pick_found, w_last, w_ready, w_push, w_push_last, w_err, w_done, w_pop, w_at_max;

    rr_pick #(.N_INPUTS(N_INPUTS), .SRC_W(SRC_W)) u_pick (
        .req   (din_valid),
        .ptr   (r_rr_ptr),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    assign w_din      = din[int'(r_grant)*DIN_WIDTH +: DIN_WIDTH];
    assign w_last     = din_last[r_grant];
    assign w_pop      = r_dout_valid & dout_ready;
    assign w_at_max   = (r_word_cnt == CNT_W'(MAX_PKT_WORDS - 1));
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign dout_src   = r_dout_src;
    assign pkt_err    = r_pkt_err;
    assign busy       = (r_state != ST_IDLE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // next state, ready gating and push/error decode; ready depends only on registered occupancy
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: if (w_pick_found) w_state_nxt = ST_XFER;
            ST_XFER: begin
                w_ready     = !(r_dout_valid && r_skid_valid);
                w_push      = w_ready && din_valid[r_grant];
                w_push_last = w_last || w_at_max;
                w_done      = w_push && w_last;
                w_err       = w_push && !w_last && w_at_max;
                w_state_nxt = w_done ? ST_IDLE : (w_err ? ST_DRAIN : ST_XFER);
            end
            ST_DRAIN: begin
                w_ready     = 1'b1;
                w_done      = din_valid[r_grant] && w_last;
                w_state_nxt = w_done ? ST_IDLE : ST_DRAIN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // only the granted source ever sees ready
    always_comb begin
        din_ready          = '0;
        din_ready[r_grant] = w_ready;
    end

    // grant capture, word counting, round-robin pointer advance and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_pkt_err <= w_err;
            if (r_state == ST_IDLE && w_pick_found) begin
                r_grant    <= w_pick_idx;
                r_word_cnt <= '0;
            end
            if (w_push) r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (w_done) r_rr_ptr <= SRC_W'(rr_next(int'(r_grant), N_INPUTS));
        end
    end

    // output register refills from the skid entry first, else straight from the pushed beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_dout_src   <= '0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_src   <= '0;
        end else begin
            if (w_push) begin
                r_skid_data <= w_din;
                r_skid_last <= w_push_last;
                r_skid_src  <= r_grant;
            end
            if (!r_dout_valid || w_pop) begin
                r_dout_valid <= r_skid_valid || w_push;
                r_skid_valid <= r_skid_valid && w_push;
                if (r_skid_valid) begin
                    r_dout      <= r_skid_data;
                    r_dout_last <= r_skid_last;
                    r_dout_src  <= r_skid_src;
                end else if (w_push) begin
                    r_dout      <= w_din;
                    r_dout_last <= w_push_last;
                    r_dout_src  <= r_grant;
                end
            end else if (w_push) begin
                r_skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// tb_stream_pkt_arbiter: scoreboard bench with per-source expected word queues and packet order
module tb_stream_pkt_arbiter;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXW = 4;
    localparam int SW   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*W-1:0]  din;
    logic [N-1:0]    din_valid, din_last, din_ready;
    logic [W-1:0]    dout;
    logic            dout_valid, dout_last, dout_ready, pkt_err, busy;
    logic [SW-1:0]   dout_src;

    logic            s_v [N];
    logic            s_l [N];
    logic [W-1:0]    s_d [N];
    logic [W:0]      src_q [N][$];
    int              order_q [$];
    int              npk [N];
    int              flen [N];
    bit              act [N];
    bit              gaps, abort, gap_chk;
    int              rdy_mode, exp_err, obs_err, n_chk, n_pass, cyc, last_cyc;

    stream_pkt_arbiter #(.N_INPUTS(N), .DIN_WIDTH(W), .MAX_PKT_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_src   (dout_src),
        .dout_ready (dout_ready),
        .pkt_err    (pkt_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_valid[i]     = s_v[i];
            din_last[i]      = s_l[i];
            din[i*W +: W]    = s_d[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    endtask

    // per-source packet generators: expectations are queued when a packet is created
    for (genvar g = 0; g < N; g++) begin : gen_src
        initial begin
            int len;
            int t;
            logic [W-1:0] w;
            s_v[g] = 1'b0;
            s_l[g] = 1'b0;
            s_d[g] = '0;
            forever begin
                @(negedge clk);
                if (npk[g] > 0 && !abort) begin
                    act[g] = 1'b1;
                    npk[g]--;
                    len = (flen[g] > 0) ? flen[g] : int'($urandom_range(1, 7));
                    if (len > MAXW) exp_err++;
                    for (int j = 0; j < len; j++) begin
                        w = $urandom;
                        if (j < MAXW) src_q[g].push_back({(j == len - 1) || (j == MAXW - 1), w});
                        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                        s_v[g] = 1'b1;
                        s_d[g] = w;
                        s_l[g] = (j == len - 1);
                        t = 0;
                        while (!din_ready[g] && !abort && t < 5000) begin
                            @(negedge clk);
                            t++;
                        end
                        if (t >= 5000) begin
                            n_chk++;
                            $display("FAIL src%0d_ready_timeout: din_ready stayed 0, required 1", g);
                        end
                        if (abort || t >= 5000) break;
                        @(negedge clk);
                        s_v[g] = 1'b0;
                        s_l[g] = 1'b0;
                    end
                    s_v[g] = 1'b0;
                    s_l[g] = 1'b0;
                    if (!abort) chk($sformatf("busy_after_last_src%0d", g), busy, 0);
                    act[g] = 1'b0;
                end
            end
        end
    end

    // downstream ready pattern: always, 1-0-0 cycle, or random
    initial begin
        int k;
        k = 0;
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            dout_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (k % 3 == 0) : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: pops expectations whenever a word leaves, checks hold stability and atomicity
    initial begin
        logic [W:0]    e;
        logic          pv, pl, in_pkt;
        logic [W-1:0]  pd;
        logic [SW-1:0] ps;
        int            cur;
        pv = 1'b0; pl = 1'b0; pd = '0; ps = '0; in_pkt = 1'b0; cur = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pv = 1'b0;
                in_pkt = 1'b0;
                continue;
            end
            if (pkt_err) obs_err++;
            if (pv) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_word", {dout_last, dout_src, dout}, {pl, ps, pd});
            end
            pv = dout_valid && !dout_ready;
            pd = dout; pl = dout_last; ps = dout_src;
            if (dout_valid && dout_ready) begin
                if (!in_pkt) begin
                    if (order_q.size() > 0) chk("pkt_src", dout_src, order_q.pop_front());
                    if (gap_chk && last_cyc >= 0) chk("pkt_gap", cyc - last_cyc, 2);
                    in_pkt = 1'b1;
                    cur = int'(dout_src);
                end else begin
                    chk("atomic_src", dout_src, cur);
                end
                if (src_q[dout_src].size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_word: src %0d data %0h appeared, required none", dout_src, dout);
                end else begin
                    e = src_q[dout_src].pop_front();
                    chk("word", {dout_last, dout}, e);
                end
                if (dout_last) begin
                    in_pkt = 1'b0;
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_drain(input int limit);
        int t;
        bit pend;
        t = 0;
        forever begin
            @(negedge clk);
            pend = dout_valid;
            for (int i = 0; i < N; i++) if (npk[i] != 0 || act[i] || src_q[i].size() != 0) pend = 1'b1;
            if (!pend) break;
            if (++t > limit) begin
                n_chk++;
                $display("FAIL drain_timeout: traffic pending after %0d cycles, required idle", limit);
                break;
            end
        end
    endtask

    task automatic wait_src_out(input int s);
        int t;
        t = 0;
        while (!(dout_valid && dout_src == SW'(s)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            $display("FAIL src_out_timeout: src %0d never appeared, required output", s);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin npk[i] = 0; flen[i] = 0; act[i] = 1'b0; end
        gaps = 0; abort = 0; gap_chk = 0; rdy_mode = 0;
        exp_err = 0; obs_err = 0; n_chk = 0; n_pass = 0; cyc = 0; last_cyc = -1;
        // reset with every source offering, then round-robin over 3-word packets
        for (int i = 0; i < N; i++) begin npk[i] = 2; flen[i] = 3; end
        repeat (3) @(negedge clk);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_misc", {dout, dout_last, dout_src, pkt_err}, 0);
        order_q = {0, 1, 2, 3, 0, 1, 2, 3};
        gap_chk = 1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arb_cycle_valid", dout_valid, 0);
        chk("arb_cycle_busy", busy, 1);
        @(negedge clk);
        chk("first_valid", dout_valid, 1);
        chk("first_src", dout_src, 0);
        wait_drain(500);
        gap_chk = 0;
        // backpressure 1,0,0 on full-length packets from src 2
        rdy_mode = 1;
        npk[2] = 3; flen[2] = 4;
        order_q = {2, 2, 2};
        wait_drain(500);
        rdy_mode = 0;
        // truncation, then an exactly-max packet
        npk[1] = 1; flen[1] = 7;
        order_q = {1};
        wait_drain(500);
        chk("trunc_err_count", obs_err, 1);
        npk[1] = 1; flen[1] = 4;
        order_q = {1};
        wait_drain(500);
        chk("exact_max_no_err", obs_err, 1);
        // contention while src 3 is mid-packet; pointer wraps to 0 before 2
        npk[3] = 1; flen[3] = 4;
        order_q = {3, 0, 2};
        wait_src_out(3);
        npk[0] = 1; flen[0] = 2;
        npk[2] = 1; flen[2] = 2;
        wait_drain(500);
        // randomized traffic with gaps and random backpressure
        gaps = 1; rdy_mode = 2;
        for (int i = 0; i < N; i++) begin npk[i] = $urandom_range(5, 12); flen[i] = 0; end
        wait_drain(8000);
        chk("random_err_count", obs_err, exp_err);
        gaps = 0; rdy_mode = 0;
        // async reset mid-packet, arbitration restarts at src 0
        npk[1] = 1; flen[1] = 2;
        order_q = {1};
        wait_drain(500);
        npk[3] = 1; flen[3] = 4;
        order_q = {3};
        wait_src_out(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", dout_valid, 0);
        chk("async_rst_ready", din_ready, 0);
        chk("async_rst_busy", busy, 0);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) src_q[i].delete();
        order_q.delete();
        abort = 1'b0;
        npk[2] = 1; flen[2] = 2;
        npk[0] = 1; flen[0] = 2;
        order_q = {0, 2};
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain(500);
        chk("final_err_count", obs_err, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_pkt_arbiter.md
Name: stream_pkt_arbiter

Overview:
- Round-robin, packet-atomic arbiter that shares one registered output stream (the 10GbE write packetizer input) between N_INPUTS valid/ready/last sources.
- Output side is a 2-entry skid stage, so it sustains one word per clock with a registered dout_ready path.
- Enforces a maximum packet length: overlong packets are truncated, the source remainder is drained, and an error pulse is raised.

Parameters:
- N_INPUTS, 4, number of requesting streams (2..16).
- DIN_WIDTH, 64, data word width.
- MAX_PKT_WORDS, 1024, maximum words per packet before forced truncation (≥2).
- SRC_W, $clog2(N_INPUTS) (min 1), width of dout_src; derived, not to be overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N_INPUTS*DIN_WIDTH  flattened input words; source i occupies bits [i*DIN_WIDTH +: DIN_WIDTH].
- din_valid  in  N_INPUTS  per-source valid.
- din_last  in  N_INPUTS  per-source end-of-packet marker.
- din_ready  out  N_INPUTS  per-source ready.
- dout  out  DIN_WIDTH  output word.
- dout_valid  out  1  output valid.
- dout_last  out  1  output end-of-packet.
- dout_src  out  SRC_W  index of the source that owns the current word.
- dout_ready  in  1  downstream ready.
- pkt_err  out  1  one-cycle pulse when a packet is truncated.
- busy  out  1  high while a grant is held (XFER or DRAIN).

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, rr_ptr=0, grant=0, word_cnt=0, skid stage empty.
  - Output reset values: dout=0, dout_valid=0, dout_last=0, dout_src=0, din_ready=0, pkt_err=0, busy=0.
  - Reset asserted mid-packet abandons the packet. No partial-packet recovery.
- Handshake: a beat transfers when valid & ready are both high in the same cycle.
  - din_ready[i] is 0 for every i ≠ grant.
  - Once dout_valid is high, dout, dout_last and dout_src stay stable until dout_ready is high.
- IDLE state:
  - din_ready=0.
  - Pick the first i with din_valid[i]=1, searching i = rr_ptr, rr_ptr+1, …, wrapping modulo N_INPUTS.
  - If one is found: grant<=i, word_cnt<=0, go to XFER.
  - Arbitration costs exactly one cycle: the first word of a packet is accepted no earlier than the cycle after the request is seen.
- XFER state:
  - din_ready[grant] = skid stage not full (registered; no combinational path from dout_ready).
  - On each accepted beat: push {din_last, grant, din} into the skid stage and increment word_cnt.
  - Accepted beat with din_last=1: rr_ptr<=(grant+1) mod N_INPUTS, go to IDLE.
  - Accepted beat with word_cnt==MAX_PKT_WORDS-1 and din_last=0: push the word with last forced to 1, pulse pkt_err, go to DRAIN.
  - A beat with last=1 at exactly MAX_PKT_WORDS words is legal: no error.
- DRAIN state:
  - din_ready[grant]=1. Accepted words are discarded, nothing is pushed.
  - On an accepted beat with last=1: rr_ptr<=grant+1, go to IDLE.
- Skid stage (2 entries):
  - Output registers are loaded from the input or from the skid register.
  - Full throughput when dout_ready is held high; output latency is 1 cycle from an accepted din beat to dout_valid.
  - Simultaneous push and pop while holding one entry keeps occupancy at 1.
  - Push into a full stage cannot occur, because din_ready is gated by not-full.
- Fairness:
  - A source that keeps valid high is granted at most once per N_INPUTS grants while others request.
  - Other sources' valid toggling has no effect mid-packet.
- busy = (state != IDLE).
- word_cnt width is $clog2(MAX_PKT_WORDS+1). It never wraps, because it is bounded by truncation.

Decomposition:
- Shared package stream_pkt_pkg holds:
  - FSM state encoding: ST_IDLE=2'd0, ST_XFER=2'd1, ST_DRAIN=2'd2.
  - Helper function rr_next(ptr, N).
- One sub-module, rr_pick: combinational rotate-and-priority-encode.
  - Inputs: req[N_INPUTS], ptr[SRC_W].
  - Outputs: found, idx[SRC_W].
  - Reusable by other arbiters in the packetizer.

Test Plan:
1. Reset/idle: hold rst_n=0 with all din_valid=1 → all outputs 0. Release → first grant is src 0; dout_valid rises 2 cycles after release (1 arbitration + 1 register).
2. Round robin: N=4, all sources continuously offer 3-word packets, dout_ready=1 → dout_src sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; dout_last on every 3rd word; one idle cycle between packets.
3. Backpressure: single 8-word packet from src 2, dout_ready toggling 1,0,0,1… → all 8 words appear in order with none lost or duplicated. dout is stable while dout_valid=1 & dout_ready=0. din_ready[2] drops within 1 cycle of the stage filling.
4. Truncation: MAX_PKT_WORDS=4, src 1 sends a 7-word packet → output shows 4 words with dout_last on the 4th, pkt_err pulses once, 3 words are drained with din_ready[1]=1, and busy falls after the 7th beat. A 4-word packet with last produces no error.
5. Mid-packet contention: src 3 is mid-packet when src 0 asserts valid → src 3 finishes uninterrupted, then src 0 is granted (rr_ptr wrapped to 0).
6. Async reset mid-XFER: assert rst_n=0 between clock edges → dout_valid and din_ready go 0 immediately. After release, arbitration restarts from src 0.
